// File: rtl/turfio_fwu_feeder.sv
// Double-buffered firmware-update byte source: streams a handed-over bank byte by byte
// into the splicer's tfio_fw_ stream, then requests that bank's MODE1 mark.
module turfio_fwu_feeder #(
  parameter int BANK_BYTES = 4096,
  parameter int LEN_BITS   = $clog2(BANK_BYTES)+1,
  parameter int WADDR_BITS = $clog2(2*BANK_BYTES/4)
) (
  input  logic                  sysclk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [WADDR_BITS-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [1:0]            bank_go_i,
  input  logic [LEN_BITS-1:0]   bank_len_i,
  output logic [1:0]            bank_busy_o,
  output logic                  next_bank_o,
  output logic [7:0]            tfio_fw_tdata,
  output logic                  tfio_fw_tvalid,
  input  logic                  tfio_fw_tready,
  output logic [1:0]            tfio_fw_mark_o,
  input  logic                  tfio_fw_marked_i
);
  localparam int BB_BITS = $clog2(BANK_BYTES);
  localparam int WORDS   = 2*BANK_BYTES/4;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_SEND, ST_MARK} state_t;

  state_t                     state_q;
  logic [1:0]                 busy_q;
  logic                       next_bank_q;
  logic [1:0][LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]        cnt_q;
  logic [7:0]                 tdata_q;
  logic                       tvalid_q;
  logic [1:0]                 mark_q;
  logic [7:0]                 rd_byte_q;
  logic [31:0]                mem_q [WORDS];

  logic                       wr_bank;
  logic [BB_BITS:0]           rd_baddr;
  logic [WADDR_BITS-1:0]      rd_waddr;
  logic [1:0]                 rd_bsel;
  logic [LEN_BITS-1:0]        len_clamp;
  logic [LEN_BITS-1:0]        len_cur;
  logic [LEN_BITS:0]          cnt_nxt;
  logic [1:0]                 mark_oh;

  assign wr_bank   = wr_addr_i[WADDR_BITS-1];
  assign rd_baddr  = {next_bank_q, cnt_q[BB_BITS-1:0]};
  assign rd_waddr  = rd_baddr[BB_BITS:2];
  assign rd_bsel   = rd_baddr[1:0];
  assign len_clamp = (bank_len_i > LEN_BITS'(BANK_BYTES)) ? LEN_BITS'(BANK_BYTES) : bank_len_i;
  assign len_cur   = len_q[next_bank_q];
  // one bit wider so the top count (BANK_BYTES) compares without wrap
  assign cnt_nxt   = {1'b0, cnt_q} + (LEN_BITS+1)'(1);
  assign mark_oh   = next_bank_q ? 2'b10 : 2'b01;

  // Bank memory is never reset; writes into a bank the feeder owns are dropped.
  always_ff @(posedge sysclk_i) begin
    if (wr_en_i && !busy_q[wr_bank]) mem_q[wr_addr_i] <= wr_data_i;
    if (state_q == ST_FETCH) rd_byte_q <= 8'(mem_q[rd_waddr] >> {rd_bsel, 3'b000});
  end

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= '0;
      next_bank_q <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      mark_q      <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (bank_go_i[b] && !busy_q[b]) begin
          busy_q[b] <= 1'b1;
          len_q[b]  <= len_clamp;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (busy_q[next_bank_q]) begin
            cnt_q <= '0;
            if (len_cur == '0) begin
              mark_q  <= mark_oh;
              state_q <= ST_MARK;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          tdata_q  <= rd_byte_q;
          tvalid_q <= 1'b1;
          state_q  <= ST_SEND;
        end
        ST_SEND: begin
          if (tfio_fw_tready) begin
            tvalid_q <= 1'b0;
            cnt_q    <= cnt_nxt[LEN_BITS-1:0];
            if (cnt_nxt == {1'b0, len_cur}) begin
              mark_q  <= mark_oh;
              state_q <= ST_MARK;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_MARK: begin
          if (tfio_fw_marked_i) begin
            mark_q              <= '0;
            busy_q[next_bank_q] <= 1'b0;
            next_bank_q         <= ~next_bank_q;
            state_q             <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bank_busy_o    = busy_q;
  assign next_bank_o    = next_bank_q;
  assign tfio_fw_tdata  = tdata_q;
  assign tfio_fw_tvalid = tvalid_q;
  assign tfio_fw_mark_o = mark_q;

endmodule
